barrel_shift_pipe: RTL and testbench
====================================

// Module: barrel_shift_pipe
// PURPOSE
//  - Parametrised, pipelined barrel shifter for the MIPS datapath.
//  - Successor to the single-cycle combinational shifter; supports SLL, SRL, SRA, ROR and ROL.
//  - Shift amount is split across STAGES register stages, with valid/ready handshakes on both sides.
//  - Carries a TAG through unchanged so the issuing unit can match results (e.g. destination register).
// PARAMETERS
//  DATA_WIDTH  32  operand width; power of two, >= 8
//  ADDR_WIDTH  5   shift-count width; equals $clog2(DATA_WIDTH)
//  STAGES      5   pipeline stages; 1..ADDR_WIDTH; ADDR_WIDTH % STAGES == 0
//  TAG_WIDTH   5   width of sideband tag carried with each operation
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous, active-low reset
//  flush        in   1           synchronous: drop all in-flight ops
//  in_valid     in   1           input operation valid
//  in_ready     out  1           block accepts the input this cycle
//  data_in      in   DATA_WIDTH  operand
//  shift_count  in   ADDR_WIDTH  shift amount 0..DATA_WIDTH-1
//  op           in   3           0 SLL, 1 SRL, 2 SRA, 3 ROR, 4 ROL, 5-7 reserved
//  tag_in       in   TAG_WIDTH   sideband tag
//  out_valid    out  1           result valid
//  out_ready    in   1           consumer accepts the result
//  data_out     out  DATA_WIDTH  shifted result
//  tag_out      out  TAG_WIDTH   tag of this result
//  illegal_op   out  1           qualified by out_valid: op was reserved
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - all stage valid bits clear, so out_valid=0;
//    - data_out, tag_out and illegal_op = 0;
//    - in_ready=1 after reset deasserts.
//  - Transfer rules:
//    - input transfer when in_valid & in_ready;
//    - output transfer when out_valid & out_ready.
//  - Shift slicing:
//    - let B = ADDR_WIDTH/STAGES;
//    - stage k (0 = first) applies the shift by shift_count[k*B +: B] << (k*B), using the op semantics;
//    - each stage registers data, op, remaining count bits, tag, illegal and valid.
//  - Composition: SLL/SRL/SRA/ROR/ROL each compose additively, so the final result equals a single
//    shift by the full shift_count.
//  - Latency is exactly STAGES cycles from input transfer to out_valid when there is no backpressure.
//    Throughput is 1 op/cycle.
//  - Stall rule:
//    - stage k advances iff !valid[k] or stage k+1 advances;
//    - the last stage advances iff !out_valid or out_ready;
//    - in_ready equals stage 0 advance. Bubbles collapse, so no slot is wasted.
//  - While out_valid=1 and out_ready=0: data_out, tag_out and illegal_op hold stable.
//  - Op semantics (n = shift amount):
//    - SLL: zero-fill from the LSB;
//    - SRL: zero-fill from the MSB;
//    - SRA: fill with data_in[MSB];
//    - ROR/ROL: bits wrap around.
//  - shift_count=0: data_out == data_in for every op.
//  - Reserved op: data passes unshifted, illegal_op=1, and the op still consumes a pipeline slot.
//  - flush:
//    - clears all valid bits next edge; out_valid=0 the following cycle;
//    - an input offered in the same cycle as flush is dropped (in_ready still reported; the
//      transfer is discarded).
//  - Reset asserted mid-operation: in-flight ops are lost, with no partial outputs.
//  - Data registers need no reset; valid bits and output registers must be reset.
// STRUCTURE
//  - barrel_shift_pkg:
//    - op localparams (OP_SLL=3'd0 ... OP_ROL=3'd4);
//    - function is_legal_op().
//  - Sub-module barrel_shift_stage, generated STAGES times:
//    - params DATA_WIDTH, B, OFFSET;
//    - one combinational slice (mux by op) plus stage registers and advance logic.
//  - The top level does the generate loop, handshake chaining, flush fan-out and parameter checks
//    ($error if ADDR_WIDTH % STAGES != 0).
// TESTING
//  - Run defaults plus STAGES=1 and STAGES=5; compare against a reference model with random ops,
//    counts and stalls.
//  - SLL: 0x12345678, count 4 -> 0x23456780, out_valid exactly 5 cycles after accept.
//  - SRL: 0x12345678, count 3 -> 0x02468ACF.
//    SRA: 0xF2345678, count 2 -> 0xFC8D159E.
//  - ROR: 0xF2345678, count 1 -> 0x791A2B3C.
//    ROL: 0x12345678, count 8 -> 0x34567812.
//    Any op with count 0 -> unchanged.
//  - Backpressure:
//    - 8 back-to-back ops with out_ready held 0 for 10 cycles;
//    - in_ready drops after 5 accepts;
//    - results emerge in order with correct tags, and data_out is stable while stalled.
//  - op=6 on 0xDEADBEEF -> data_out 0xDEADBEEF, illegal_op=1.
//    Flush with 3 ops in flight -> none emerge, and the next op completes normally.
//  - Assert rst_n=0 mid-stream -> out_valid=0 immediately (async), in_ready=1 after release.

Source files
------------

// File: rtl/barrel_shift_pkg.sv
// barrel_shift_pkg: op encodings and legality helper shared by the pipelined shifter
package barrel_shift_pkg;
    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction
endpackage

// File: rtl/barrel_shift_stage.sv
// barrel_shift_stage: one slice of the shift amount plus its stage registers and advance logic
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int B          = 1,
    parameter int OFFSET     = 0,
    parameter int ADDR_WIDTH = 5,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic [2:0]            up_op,
    input  logic [ADDR_WIDTH-1:0] up_count,
    input  logic [TAG_WIDTH-1:0]  up_tag,
    input  logic                  up_illegal,
    input  logic                  down_advance,
    output logic                  advance,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [2:0]            op,
    output logic [ADDR_WIDTH-1:0] count,
    output logic [TAG_WIDTH-1:0]  tag,
    output logic                  illegal
);
    logic [ADDR_WIDTH-1:0] n;
    logic [DATA_WIDTH-1:0] sra, ror, rol, res;

    assign n       = ADDR_WIDTH'(up_count[OFFSET +: B]) << OFFSET;
    assign advance = !valid || down_advance;

    // This slice's partial shift; reserved ops pass the data through untouched
    always_comb begin
        sra = $signed(up_data) >>> n;
        ror = DATA_WIDTH'({up_data, up_data} >> n);
        rol = DATA_WIDTH'(({up_data, up_data} << n) >> DATA_WIDTH);
        res = up_op == OP_SLL ? up_data << n :
              up_op == OP_SRL ? up_data >> n :
              up_op == OP_SRA ? sra :
              up_op == OP_ROR ? ror :
              up_op == OP_ROL ? rol : up_data;
    end

    // Stage registers: flush kills the valid bit, payload only loads with a real op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            data    <= '0;
            op      <= '0;
            count   <= '0;
            tag     <= '0;
            illegal <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (advance) begin
            valid <= up_valid;
            if (up_valid) begin
                data    <= res;
                op      <= up_op;
                count   <= up_count;
                tag     <= up_tag;
                illegal <= up_illegal;
            end
        end
    end
endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined barrel shifter with valid/ready handshakes and tag sideband
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STAGES     = 5,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] shift_count,
    input  logic [2:0]            op,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [TAG_WIDTH-1:0]  tag_out,
    output logic                  illegal_op
);
    localparam int B = ADDR_WIDTH / STAGES;

    if (ADDR_WIDTH % STAGES != 0) begin : g_bad_split
        $error("barrel_shift_pipe: ADDR_WIDTH must be a multiple of STAGES");
    end
    if (ADDR_WIDTH != $clog2(DATA_WIDTH)) begin : g_bad_width
        $error("barrel_shift_pipe: ADDR_WIDTH must equal clog2(DATA_WIDTH)");
    end

    logic                  st_valid   [STAGES+1];
    logic                  st_advance [STAGES+1];
    logic [DATA_WIDTH-1:0] st_data    [STAGES+1];
    logic [2:0]            st_op      [STAGES+1];
    logic [ADDR_WIDTH-1:0] st_count   [STAGES+1];
    logic [TAG_WIDTH-1:0]  st_tag     [STAGES+1];
    logic                  st_illegal [STAGES+1];

    assign st_valid[0]        = in_valid;
    assign st_data[0]         = data_in;
    assign st_op[0]           = op;
    assign st_count[0]        = shift_count;
    assign st_tag[0]          = tag_in;
    assign st_illegal[0]      = !is_legal_op(op);
    assign st_advance[STAGES] = out_ready;

    assign in_ready   = st_advance[0];
    assign out_valid  = st_valid[STAGES];
    assign data_out   = st_data[STAGES];
    assign tag_out    = st_tag[STAGES];
    assign illegal_op = st_illegal[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        barrel_shift_stage #(
            .DATA_WIDTH(DATA_WIDTH),
            .B         (B),
            .OFFSET    (k * B),
            .ADDR_WIDTH(ADDR_WIDTH),
            .TAG_WIDTH (TAG_WIDTH)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush),
            .up_valid    (st_valid[k]),
            .up_data     (st_data[k]),
            .up_op       (st_op[k]),
            .up_count    (st_count[k]),
            .up_tag      (st_tag[k]),
            .up_illegal  (st_illegal[k]),
            .down_advance(st_advance[k+1]),
            .advance     (st_advance[k]),
            .valid       (st_valid[k+1]),
            .data        (st_data[k+1]),
            .op          (st_op[k+1]),
            .count       (st_count[k+1]),
            .tag         (st_tag[k+1]),
            .illegal     (st_illegal[k+1])
        );
    end
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: random and directed checks of the shifter against a queue-based model
module tb_barrel_shift_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, illegal_op;
    logic [31:0] data_in = '0, data_out;
    logic [4:0]  shift_count = '0, tag_in = '0, tag_out;
    logic [2:0]  op = '0;
    int          errors = 0, checks = 0, idx = 0;
    logic [31:0] bp_d [8];
    logic [2:0]  bp_o [8];
    logic [4:0]  bp_c [8];

    typedef struct {logic [31:0] d; logic [4:0] t; logic il;} exp_t;
    exp_t q[$];

    barrel_shift_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift_count(shift_count), .op(op), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .tag_out(tag_out), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] d, input int n);
        logic [31:0] r = d;
        case (o)
            3'd0: r = d * (32'd1 << n);
            3'd1: r = d / (32'd1 << n);
            3'd2: for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
            3'd3: for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
            3'd4: for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
            default: r = d;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) q.delete();
        else begin
            if (out_valid) begin
                if (q.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'd0);
                else begin
                    check("data_out", data_out, q[0].d);
                    check("tag_out", 32'(tag_out), 32'(q[0].t));
                    check("illegal_op", 32'(illegal_op), 32'(q[0].il));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready)
                q.push_back('{ref_shift(op, data_in, int'(shift_count)), tag_in, op > 3'd4});
        end
    end

    task automatic send(input logic [2:0] o, input logic [31:0] d, input logic [4:0] c, input logic [4:0] t);
        bit ok = 1'b0;
        op = o; data_in = d; shift_count = c; tag_in = t; in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accept", 32'(ok), 32'd1);
    endtask

    task automatic directed(input string name, input logic [2:0] o, input logic [31:0] d,
                            input logic [4:0] c, input logic [31:0] exp, input logic il);
        int lat = 1;
        send(o, d, c, 5'($urandom));
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd5);
        check(name, data_out, exp);
        check({name, "_illegal"}, 32'(illegal_op), 32'(il));
        @(posedge clk); #1;
    endtask

    task automatic feed(input int cycles);
        bit fire;
        for (int c = 0; c < cycles && idx < 8; c++) begin
            in_valid = 1'b1; op = bp_o[idx]; data_in = bp_d[idx]; shift_count = bp_c[idx];
            tag_in = 5'(idx);
            @(negedge clk);
            fire = in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 40 && q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_tag_out", 32'(tag_out), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        directed("sll", 3'd0, 32'h12345678, 5'd4, 32'h23456780, 1'b0);
        directed("srl", 3'd1, 32'h12345678, 5'd3, 32'h02468ACF, 1'b0);
        directed("sra", 3'd2, 32'hF2345678, 5'd2, 32'hFC8D159E, 1'b0);
        directed("ror", 3'd3, 32'hF2345678, 5'd1, 32'h791A2B3C, 1'b0);
        directed("rol", 3'd4, 32'h12345678, 5'd8, 32'h34567812, 1'b0);
        directed("reserved", 3'd6, 32'hDEADBEEF, 5'd7, 32'hDEADBEEF, 1'b1);
        for (int o = 0; o < 5; o++) directed("count_zero", 3'(o), 32'hA5C30F96, 5'd0, 32'hA5C30F96, 1'b0);

        for (int i = 0; i < 8; i++) begin
            bp_d[i] = $urandom; bp_o[i] = 3'($urandom % 5); bp_c[i] = 5'($urandom);
        end
        out_ready = 1'b0;
        idx = 0;
        feed(10);
        check("bp_accepts", 32'(idx), 32'd5);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        feed(20);
        check("bp_all_accepted", 32'(idx), 32'd8);
        drain("bp_drain");

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op = 3'($urandom % 5); data_in = $urandom; shift_count = 5'($urandom); tag_in = 5'(i);
            @(posedge clk); #1;
        end
        flush = 1'b1; data_in = 32'h0BAD0BAD; tag_in = 5'd9;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("flush_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        directed("post_flush", 3'd1, 32'h80000000, 5'd31, 32'h00000001, 1'b0);

        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom % 4) != 0;
            op = 3'($urandom % 8); data_in = $urandom; shift_count = 5'($urandom); tag_in = 5'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush = ($urandom % 60) == 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drain("random_drain");

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(3'($urandom % 5), $urandom, 5'($urandom), 5'(i));
        repeat (6) @(posedge clk);
        #1 check("stall_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_data_out", data_out, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        directed("post_reset", 3'd4, 32'h12345678, 5'd8, 32'h34567812, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
